// File: rtl/digit_serial_addsub.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock over WIDTH/DIGIT cycles,
// with valid/ready handshakes on both sides and carry/borrow, overflow, zero and negative flags.
module digit_serial_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iMode,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oCarry,
    output logic             oOverflow,
    output logic             oZero,
    output logic             oNeg
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_mode;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_result;
    logic             r_carry_flag;
    logic             r_ovf_flag;
    logic             r_zero_flag;
    logic             r_neg_flag;

    logic [DIGIT-1:0] w_a_d;
    logic [DIGIT-1:0] w_b_d;
    logic [DIGIT:0]   w_dsum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_accept;

    // Subtraction uses A + ~B with the inverted borrow as internal carry-in.
    assign w_a_d      = r_a[DIGIT-1:0];
    assign w_b_d      = r_b[DIGIT-1:0] ^ {DIGIT{r_mode}};
    assign w_dsum     = {1'b0, w_a_d} + {1'b0, w_b_d} + (DIGIT+1)'(r_carry);
    assign w_msb_cin  = w_a_d[DIGIT-1] ^ w_b_d[DIGIT-1] ^ w_dsum[DIGIT-1];
    assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_accept   = iValid && (r_state == S_IDLE);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (iValid) w_state_next = S_BUSY;
            S_BUSY: if (w_last) w_state_next = S_DONE;
            S_DONE: if (iReady) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_mode       <= 1'b0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_carry_flag <= 1'b0;
            r_ovf_flag   <= 1'b0;
            r_zero_flag  <= 1'b0;
            r_neg_flag   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= iA;
            r_b     <= iB;
            r_mode  <= iMode;
            r_carry <= iC ^ iMode;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_BUSY) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_next;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_result     <= w_sum_next;
                r_carry_flag <= w_dsum[DIGIT] ^ r_mode;
                r_ovf_flag   <= w_msb_cin ^ w_dsum[DIGIT];
                r_zero_flag  <= (w_sum_next == '0);
                r_neg_flag   <= w_sum_next[WIDTH-1];
            end
        end
    end

    assign oReady    = (r_state == S_IDLE);
    assign oValid    = (r_state == S_DONE);
    assign oResult   = r_result;
    assign oCarry    = r_carry_flag;
    assign oOverflow = r_ovf_flag;
    assign oZero     = r_zero_flag;
    assign oNeg      = r_neg_flag;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT=4, 1, 16) share a clock and reset;
// expected results come from a behavioural model via a scoreboard queue.
module tb_digit_serial_addsub;

    typedef struct packed {
        logic [15:0] res;
        logic        carry;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        vin   [3];
    logic        ordy  [3];
    logic        mode  [3];
    logic [15:0] a     [3];
    logic [15:0] b     [3];
    logic        cin   [3];
    logic        ov    [3];
    logic        rin   [3];
    logic [15:0] res   [3];
    logic        carry [3];
    logic        ovf   [3];
    logic        zero  [3];
    logic        neg   [3];

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          nlat  [3] = '{4, 16, 1};
    exp_t        q[$];
    exp_t        last_e;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        digit_serial_addsub #(.WIDTH(16), .DIGIT(D)) u_dut (
            .iClk     (clk),
            .iRst_n   (rst_n),
            .iValid   (vin[g]),
            .oReady   (ordy[g]),
            .iMode    (mode[g]),
            .iA       (a[g]),
            .iB       (b[g]),
            .iC       (cin[g]),
            .oValid   (ov[g]),
            .iReady   (rin[g]),
            .oResult  (res[g]),
            .oCarry   (carry[g]),
            .oOverflow(ovf[g]),
            .oZero    (zero[g]),
            .oNeg     (neg[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                   input logic c);
        exp_t        e;
        logic [16:0] full;
        if (!m) begin
            full    = {1'b0, x} + {1'b0, y} + 17'(c);
            e.carry = full[16];
            e.ovf   = (x[15] == y[15]) && (full[15] != x[15]);
        end else begin
            full    = {1'b0, x} - {1'b0, y} - 17'(c);
            e.carry = ({1'b0, x} < ({1'b0, y} + 17'(c)));
            e.ovf   = (x[15] != y[15]) && (full[15] != x[15]);
        end
        e.res  = full[15:0];
        e.zero = (full[15:0] == 16'h0000);
        e.neg  = full[15];
        return e;
    endfunction

    task automatic start_op(input int u, input logic m, input logic [15:0] x,
                            input logic [15:0] y, input logic c);
        check($sformatf("u%0d ready_idle", u), 32'(ordy[u]), 32'd1);
        mode[u] = m;
        a[u]    = x;
        b[u]    = y;
        cin[u]  = c;
        vin[u]  = 1'b1;
        q.push_back(model(m, x, y, c));
        @(posedge clk);
        #1;
        vin[u]  = 1'b0;
        // Scramble operands: only the values at acceptance may matter.
        a[u]    = 16'($urandom);
        b[u]    = 16'($urandom);
        mode[u] = ~m;
        cin[u]  = ~c;
    endtask

    task automatic collect(input int u);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (ov[u] !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("u%0d latency", u), 32'(cyc), 32'(nlat[u]));
        if (q.size() == 0) begin
            check($sformatf("u%0d scoreboard_empty", u), 32'(1), 32'(0));
        end else begin
            e      = q.pop_front();
            last_e = e;
            check($sformatf("u%0d result", u), 32'(res[u]), 32'(e.res));
            check($sformatf("u%0d carry", u), 32'(carry[u]), 32'(e.carry));
            check($sformatf("u%0d overflow", u), 32'(ovf[u]), 32'(e.ovf));
            check($sformatf("u%0d zero", u), 32'(zero[u]), 32'(e.zero));
            check($sformatf("u%0d neg", u), 32'(neg[u]), 32'(e.neg));
            check($sformatf("u%0d ready_done", u), 32'(ordy[u]), 32'd0);
        end
    endtask

    task automatic release_op(input int u);
        rin[u] = 1'b1;
        @(posedge clk);
        #1;
        rin[u] = 1'b0;
        check($sformatf("u%0d valid_clear", u), 32'(ov[u]), 32'd0);
        check($sformatf("u%0d ready_back", u), 32'(ordy[u]), 32'd1);
    endtask

    task automatic run_op(input int u, input logic m, input logic [15:0] x,
                          input logic [15:0] y, input logic c);
        start_op(u, m, x, y, c);
        collect(u);
        release_op(u);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i]  = 1'b0;
            mode[i] = 1'b0;
            a[i]    = '0;
            b[i]    = '0;
            cin[i]  = 1'b0;
            rin[i]  = 1'b0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d rst_valid", i), 32'(ov[i]), 32'd0);
            check($sformatf("u%0d rst_ready", i), 32'(ordy[i]), 32'd1);
            check($sformatf("u%0d rst_result", i),
                  {res[i], 12'h0, carry[i], ovf[i], zero[i], neg[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int u = 0; u < 3; u++) begin
            run_op(u, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
            run_op(u, 1'b1, 16'h0000, 16'h0001, 1'b0);
            run_op(u, 1'b1, 16'h8000, 16'h0001, 1'b0);
            run_op(u, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
            run_op(u, 1'b1, 16'h0005, 16'h0004, 1'b1);
            run_op(u, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
            run_op(u, 1'b1, 16'h1234, 16'hA5A5, 1'b1);
            run_op(u, 1'b0, 16'h8001, 16'h8001, 1'b1);
        end

        // Backpressure: result held for 3 cycles while a new request is presented.
        start_op(0, 1'b0, 16'hBEEF, 16'h1111, 1'b1);
        collect(0);
        mode[0] = 1'b1;
        a[0]    = 16'h4000;
        b[0]    = 16'h0001;
        cin[0]  = 1'b0;
        vin[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid_held", 32'(ov[0]), 32'd1);
            check("bp_ready_low", 32'(ordy[0]), 32'd0);
            check("bp_result_stable", 32'(res[0]), 32'(last_e.res));
        end
        q.push_back(model(1'b1, 16'h4000, 16'h0001, 1'b0));
        release_op(0);
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        check("bp_second_accepted", 32'(ordy[0]), 32'd0);
        collect(0);
        release_op(0);

        // Reset during BUSY, then a fresh operation.
        start_op(0, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(q.pop_back());
        #1;
        check("midrst_valid", 32'(ov[0]), 32'd0);
        check("midrst_ready", 32'(ordy[0]), 32'd1);
        check("midrst_result", 32'(res[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("postrst_no_valid", 32'(ov[0]), 32'd0);
        end
        run_op(0, 1'b1, 16'h0005, 16'h0004, 1'b1);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
